// File: rtl/mon_sopc_mem_pkg.sv
// Shared definitions for the mon_sopc RAM fill/check initiator.
// Holds op encodings, the sequencer state enum, the pattern LFSR taps and the RAM depth.
// Latency/backpressure: not applicable (declarations only).
package mon_sopc_mem_pkg;

   localparam int DEPTH_DEFAULT = 5000;

   localparam logic OP_FILL  = 1'b0;
   localparam logic OP_CHECK = 1'b1;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_FIN
   } state_t;

   // One right-shifting Galois step: when the bit shifted out is set, fold in the taps.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/mon_sopc_pattern_gen.sv
// Pattern word source shared by FILL and CHECK: load() restarts at the seed, step() advances.
// Latency: new word visible the cycle after load/step. No backpressure; caller gates step.
// Build option MON_SOPC_MEM_INIT_LFSR_EN selects a Galois LFSR instead of seed+k.
module mon_sopc_pattern_gen
   import mon_sopc_mem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [DATA_W-1:0] seed_i,
   input  logic              step_i,
   output logic [DATA_W-1:0] pat_o
);

   logic [DATA_W-1:0] pat_q;
   logic [DATA_W-1:0] pat_d;

   // Next pattern word: load wins over step so a fresh sequence always starts at the seed.
   always_comb begin
      pat_d = pat_q;
`ifdef MON_SOPC_MEM_INIT_LFSR_EN
      if (load_i) begin
         // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
         pat_d = (seed_i == '0) ? DATA_W'(1) : seed_i;
      end else if (step_i) begin
         pat_d = DATA_W'(lfsr_step(32'(pat_q)));
      end
`else
      if (load_i) begin
         pat_d = seed_i;
      end else if (step_i) begin
         pat_d = pat_q + DATA_W'(1);
      end
`endif
   end

   // Pattern register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q <= '0;
      end else begin
         pat_q <= pat_d;
      end
   end

   assign pat_o = pat_q;

endmodule

// File: rtl/mon_sopc_mem_initiator.sv
// Avalon-MM master that FILLs a RAM word range with a pattern or CHECKs it, counting mismatches.
// Latency: FILL N words -> done N+1 cycles after start; CHECK 2 cycles/word with 1-cycle read data.
// Backpressure: waitrequest holds the command stable; exactly one read outstanding at a time.
// Build option MON_SOPC_MEM_INIT_LFSR_EN (in mon_sopc_pattern_gen) switches the pattern to an LFSR.
module mon_sopc_mem_initiator
   import mon_sopc_mem_pkg::*;
#(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int DEPTH  = DEPTH_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                op,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W-1:0]   num_words,
   input  logic [DATA_W-1:0]   seed,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   err_count,
   output logic [ADDR_W-1:0]   first_err_addr,
   output logic [ADDR_W-1:0]   avm_address,
   output logic [DATA_W/8-1:0] avm_byteenable,
   output logic                avm_chipselect,
   output logic                avm_write,
   output logic                avm_read,
   output logic [DATA_W-1:0]   avm_writedata,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_waitrequest,
   input  logic                avm_readdatavalid
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ERR_MAX   = '1;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] err_q;
   logic [ADDR_W-1:0] first_q;
   logic              seen_q;
   logic              busy_q;
   logic              done_q;
   logic              wr_q;
   logic              rd_q;

   logic [ADDR_W-1:0] addr_d;
   logic              last_word;
   logic              pat_load;
   logic              pat_step;
   logic [DATA_W-1:0] pat;

   // Sequential word address wraps at the end of the RAM, not at the address-width boundary.
   assign addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
   assign last_word = (cnt_q == ADDR_W'(1));

   // The pattern advances exactly when a word is consumed: write accepted or read data compared.
   assign pat_load = (state_q == ST_IDLE) && start;
   assign pat_step = ((state_q == ST_WR) && !avm_waitrequest) ||
                     ((state_q == ST_RD_WAIT) && avm_readdatavalid);

   mon_sopc_pattern_gen #(
      .DATA_W (DATA_W)
   ) u_pattern_gen (
      .clk    (clk),
      .reset  (reset),
      .load_i (pat_load),
      .seed_i (seed),
      .step_i (pat_step),
      .pat_o  (pat)
   );

   // Sequencer: latches the job on start, walks the range and owns every registered output.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         first_q <= '0;
         seen_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  addr_q  <= (base_addr > LAST_ADDR) ? '0 : base_addr;
                  cnt_q   <= num_words;
                  err_q   <= '0;
                  first_q <= '0;
                  seen_q  <= 1'b0;
                  if (num_words == '0) begin
                     done_q  <= 1'b1;
                     state_q <= ST_FIN;
                  end else if (op == OP_CHECK) begin
                     busy_q  <= 1'b1;
                     rd_q    <= 1'b1;
                     state_q <= ST_RD_REQ;
                  end else begin
                     busy_q  <= 1'b1;
                     wr_q    <= 1'b1;
                     state_q <= ST_WR;
                  end
               end
            end

            ST_WR: begin
               if (!avm_waitrequest) begin
                  addr_q <= addr_d;
                  cnt_q  <= cnt_q - ADDR_W'(1);
                  if (last_word) begin
                     wr_q    <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_FIN;
                  end
               end
            end

            ST_RD_REQ: begin
               if (!avm_waitrequest) begin
                  rd_q    <= 1'b0;
                  state_q <= ST_RD_WAIT;
               end
            end

            ST_RD_WAIT: begin
               if (avm_readdatavalid) begin
                  if (avm_readdata != pat) begin
                     if (err_q != ERR_MAX) begin
                        err_q <= err_q + ADDR_W'(1);
                     end
                     if (!seen_q) begin
                        first_q <= addr_q;
                        seen_q  <= 1'b1;
                     end
                  end
                  addr_q <= addr_d;
                  cnt_q  <= cnt_q - ADDR_W'(1);
                  if (last_word) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_FIN;
                  end else begin
                     rd_q    <= 1'b1;
                     state_q <= ST_RD_REQ;
                  end
               end
            end

            ST_FIN: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign err_count      = err_q;
   assign first_err_addr = first_q;
   assign avm_chipselect = wr_q | rd_q;
   assign avm_write      = wr_q;
   assign avm_read       = rd_q;
   assign avm_address    = avm_chipselect ? addr_q : '0;
   assign avm_byteenable = {(DATA_W/8){avm_chipselect}};
   assign avm_writedata  = wr_q ? pat : '0;

endmodule

// File: tb/tb_mon_sopc_mem_initiator.sv
// Self-checking bench for mon_sopc_mem_initiator with a 1-cycle-latency RAM slave model.
// Table of directed FILL/CHECK jobs plus hand sequences for busy/FIN starts, mid-run reset, stray readdatavalid.
// Slave model can insert random waitrequest stalls and watches command stability and read ordering.
module tb_mon_sopc_mem_initiator;

   localparam int AW  = 13;
   localparam int DW  = 32;
   localparam int DEP = 5000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          op = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] num_words = '0;
   logic [DW-1:0] seed = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] err_count;
   logic [AW-1:0] first_err_addr;
   logic [AW-1:0] avm_address;
   logic [3:0]    avm_byteenable;
   logic          avm_chipselect;
   logic          avm_write;
   logic          avm_read;
   logic [DW-1:0] avm_writedata;
   logic [DW-1:0] avm_readdata = '0;
   logic          avm_waitrequest = 1'b0;
   logic          avm_readdatavalid = 1'b0;

   mon_sopc_mem_initiator dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .op                (op),
      .base_addr         (base_addr),
      .num_words         (num_words),
      .seed              (seed),
      .busy              (busy),
      .done              (done),
      .err_count         (err_count),
      .first_err_addr    (first_err_addr),
      .avm_address       (avm_address),
      .avm_byteenable    (avm_byteenable),
      .avm_chipselect    (avm_chipselect),
      .avm_write         (avm_write),
      .avm_read          (avm_read),
      .avm_writedata     (avm_writedata),
      .avm_readdata      (avm_readdata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid)
   );

   always #5 clk = ~clk;

   logic [79:0] out_vec;
   assign out_vec = {busy, done, err_count, first_err_addr, avm_address, avm_byteenable,
                     avm_chipselect, avm_write, avm_read, avm_writedata};

   int tests = 0;
   int fails = 0;

   // RAM slave model state; written only by the model process below.
   logic [DW-1:0] mem [0:DEP-1];
   int            wl_addr[$];
   logic [DW-1:0] wl_data[$];
   int            cs_cnt = 0;
   int            stab_err = 0;
   int            proto_err = 0;
   bit            pending = 0;
   int            paddr = 0;
   bit            hold_prev = 0;
   logic [47:0]   prev_cmd = '0;
   logic [47:0]   cur_cmd;
   int            corrupt_seen = 0;

   // Requests from the stimulus process to the model.
   bit            stall_en = 0;
   bit            spur = 0;
   int            corrupt_addr = 0;
   int            corrupt_seq = 0;

   // Slave model: acts on the negative edge so the DUT sees stable inputs at the next rising edge.
   always @(negedge clk) begin
      if (corrupt_seq != corrupt_seen) begin
         mem[corrupt_addr] = mem[corrupt_addr] ^ 32'h0000_00FF;
         corrupt_seen = corrupt_seq;
      end
      if (reset) begin
         pending = 0;
         hold_prev = 0;
         avm_readdatavalid = 1'b0;
         avm_readdata = '0;
         avm_waitrequest = 1'b0;
      end else begin
         if (pending && avm_read) proto_err++;
         if ((avm_chipselect !== (avm_read | avm_write)) || (avm_read && avm_write)) proto_err++;
         if (avm_chipselect && (avm_byteenable !== 4'hF)) proto_err++;
         if (avm_chipselect && (int'(avm_address) >= DEP)) proto_err++;
         avm_readdatavalid = 1'b0;
         avm_readdata = '0;
         if (pending) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = mem[paddr];
            pending = 0;
         end else if (spur) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = 32'hDEAD_BEEF;
         end
         cur_cmd = {avm_address, avm_write, avm_read, 1'b0, avm_writedata};
         if (hold_prev && (cur_cmd !== prev_cmd)) stab_err++;
         avm_waitrequest = 1'b0;
         if (avm_chipselect) begin
            cs_cnt++;
            if (stall_en) avm_waitrequest = ($urandom_range(0, 1) == 1);
            if (!avm_waitrequest && (int'(avm_address) < DEP)) begin
               if (avm_write) begin
                  mem[avm_address] = avm_writedata;
                  wl_addr.push_back(int'(avm_address));
                  wl_data.push_back(avm_writedata);
               end
               if (avm_read) begin
                  pending = 1;
                  paddr = int'(avm_address);
               end
            end
         end
         hold_prev = avm_chipselect && avm_waitrequest;
         prev_cmd = cur_cmd;
      end
   end

   task automatic chk_i(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   typedef struct {
      bit          op;
      int          base;
      int          n;
      logic [31:0] seed;
      bit          stall;
      int          corrupt;
      int          exp_err;
      int          exp_first;
      int          exp_cyc;
   } vec_t;

   task automatic run_vec(input vec_t v, input string tag);
      int cyc;
      int wb;
      int cb;
      int a0;
      bit ok;
      if (v.corrupt >= 0) begin
         corrupt_addr = v.corrupt;
         corrupt_seq++;
         @(negedge clk);
         @(negedge clk);
      end
      @(negedge clk);
      stall_en  = v.stall;
      op        = v.op;
      base_addr = AW'(v.base);
      num_words = AW'(v.n);
      seed      = v.seed;
      start     = 1'b1;
      wb = wl_addr.size();
      cb = cs_cnt;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk_i({tag, "_done_seen"}, int'(done === 1'b1), 1);
      if (v.exp_cyc >= 0) chk_i({tag, "_done_cycle"}, cyc, v.exp_cyc);
      chk_i({tag, "_busy_at_done"}, int'(busy), 0);
      chk_i({tag, "_err_count"}, int'(err_count), v.exp_err);
      chk_i({tag, "_first_err_addr"}, int'(first_err_addr), v.exp_first);
      ok = 1;
      if (v.op == 1'b0) begin
         if (wl_addr.size() - wb != v.n) begin
            ok = 0;
         end else begin
            a0 = (v.base >= DEP) ? 0 : v.base;
            for (int k = 0; k < v.n; k++) begin
               if (wl_addr[wb + k] != (a0 + k) % DEP) ok = 0;
               if (wl_data[wb + k] !== v.seed + 32'(k)) ok = 0;
            end
         end
      end else if (wl_addr.size() != wb) begin
         ok = 0;
      end
      chk_i({tag, "_write_log"}, int'(ok), 1);
      if (v.n == 0) chk_i({tag, "_no_chipselect"}, cs_cnt - cb, 0);
      stall_en = 0;
   endtask

   vec_t vecs[11];
   vec_t v;
   int   dn;
   int   cb0;
   int   wb0;
   bit   ok0;

   initial begin
      //          op    base  n     seed          stall corrupt err first cyc
      vecs[0]  = '{1'b0, 0,    4,    32'h10,       1'b0, -1,     0,  0,    5};
      vecs[1]  = '{1'b1, 0,    4,    32'h10,       1'b0, -1,     0,  0,    9};
      vecs[2]  = '{1'b1, 0,    4,    32'h10,       1'b0, 2,      1,  2,    9};
      vecs[3]  = '{1'b0, 4998, 4,    32'hFFFFFFFE, 1'b1, -1,     0,  0,    -1};
      vecs[4]  = '{1'b1, 4998, 4,    32'hFFFFFFFE, 1'b1, -1,     0,  0,    -1};
      vecs[5]  = '{1'b1, 1,    3,    32'h1,        1'b0, -1,     2,  2,    7};
      vecs[6]  = '{1'b0, 6000, 2,    32'hA0,       1'b0, -1,     0,  0,    3};
      vecs[7]  = '{1'b0, 0,    0,    32'h55,       1'b0, -1,     0,  0,    1};
      vecs[8]  = '{1'b1, 7,    0,    32'h55,       1'b0, -1,     0,  0,    1};
      vecs[9]  = '{1'b0, 10,   5000, 32'h0,        1'b0, -1,     0,  0,    5001};
      vecs[10] = '{1'b1, 10,   5000, 32'h0,        1'b0, -1,     0,  0,    10001};

      // Reset state.
      repeat (3) @(negedge clk);
      chk_i("reset_outputs_zero", int'(out_vec != '0), 0);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Start while busy and start during the done cycle are both ignored.
      @(negedge clk);
      op = 1'b0; base_addr = AW'(20); num_words = AW'(3); seed = 32'h30; start = 1'b1;
      wb0 = wl_addr.size();
      @(negedge clk);
      start = 1'b0;
      chk_i("busy_cycle1", int'(busy), 1);
      @(negedge clk);
      op = 1'b1; base_addr = AW'(100); num_words = AW'(1); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk_i("done_cycle4_despite_busy_start", int'(done), 1);
      op = 1'b0; base_addr = AW'(200); num_words = AW'(1); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_i("fin_start_ignored_busy", int'(busy), 0);
      cb0 = cs_cnt;
      repeat (4) @(negedge clk);
      chk_i("fin_start_ignored_no_access", cs_cnt - cb0, 0);
      ok0 = (wl_addr.size() - wb0 == 3);
      if (ok0) begin
         for (int k = 0; k < 3; k++) begin
            if (wl_addr[wb0 + k] != 20 + k || wl_data[wb0 + k] !== 32'h30 + 32'(k)) ok0 = 0;
         end
      end
      chk_i("busy_start_write_log", int'(ok0), 1);

      // Reset in the middle of a CHECK: outputs clear, no done pulse afterwards.
      @(negedge clk);
      op = 1'b1; base_addr = AW'(0); num_words = AW'(4); seed = 32'd4990; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_i("midrun_reset_outputs_zero", int'(out_vec != '0), 0);
      reset = 1'b0;
      dn = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
      end
      chk_i("midrun_reset_no_done", dn, 0);

      // Fresh CHECK after the aborted one, over words written by vec9, with word 2 corrupted.
      v = '{1'b1, 0, 4, 32'd4990, 1'b0, 2, 1, 2, 9};
      run_vec(v, "post_reset_check");

      // Stray readdatavalid while idle must not disturb the result registers.
      @(negedge clk);
      spur = 1'b1;
      repeat (3) @(negedge clk);
      spur = 1'b0;
      @(negedge clk);
      chk_i("stray_rdv_err_count", int'(err_count), 1);
      chk_i("stray_rdv_first_err_addr", int'(first_err_addr), 2);

      chk_i("cmd_stable_under_waitrequest", stab_err, 0);
      chk_i("bus_protocol", proto_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
